user_cl_adder_stim: RTL and testbench

- Traffic generator and checker on the host-side ends of the adder's two FIFOs.
- Writes LFSR-generated operand words into the input FIFO, which the adder reads.
- Pops adder results from the output FIFO, which the adder writes, and compares each against a lockstep-regenerated expected sum.
- Reports pass/error counts, the first mismatch, and a no-response timeout; used for on-FPGA self-test of the CL.

---
 rtl/user_cl_pkg.sv | 19 +
 rtl/user_cl_lfsr8.sv | 21 ++
 rtl/user_cl_adder_stim.sv | 148 ++++++++++++++
 tb/tb_user_cl_adder_stim.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_cl_pkg.sv
// Shared constants for the CL adder traffic generator/checker.
// FSM encodings, LFSR taps and the default FIFO width.
package user_cl_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] l
  );
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/user_cl_lfsr8.sv
// 8-bit Fibonacci LFSR with seed load and advance enable.
// Load wins over advance.
import user_cl_pkg::*;

module user_cl_lfsr8 (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              adv,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] value
);

  // state register: seed on load, one step per advance
  always_ff @(posedge clock) begin
    if (!reset_n) value <= '0;
    else if (load) value <= seed;
    else if (adv) value <= lfsr_next(value);
  end

endmodule

// File: rtl/user_cl_adder_stim.sv
// Host-side stimulus and checker for the CL adder FIFO pair.
// Issues LFSR operands, pops results, counts matches.
import user_cl_pkg::*;

module user_cl_adder_stim #(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [15:0]           num_ops,
  input  logic [7:0]            seed,
  input  logic                  in_full,
  output logic                  in_wr,
  output logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  out_empty,
  output logic                  out_rd,
  input  logic [DATA_WIDTH-1:0] out_din,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [15:0]           pass_count,
  output logic [15:0]           err_count,
  output logic [15:0]           first_err_idx,
  output logic [DATA_WIDTH-1:0] first_err_data
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]            state;
  logic [15:0]           ops;
  logic [15:0]           issued;
  logic [15:0]           checked;
  logic [WD_W-1:0]       wd;
  logic [LFSR_W-1:0]     g;
  logic [LFSR_W-1:0]     c;
  logic [LFSR_W-1:0]     seed_eff;
  logic [4:0]            nib_sum;
  logic [DATA_WIDTH-1:0] exp_word;
  logic                  accept;
  logic                  run;
  logic                  more_chk;
  logic                  pop;
  logic                  wd_hit;
  logic                  fin;
  logic                  issue;

  assign seed_eff = (seed == 8'h00) ? 8'h01 : seed;
  assign run      = (state == RUN);
  assign busy     = run;
  assign accept   = start && !run;
  assign more_chk = (checked < ops);
  assign pop      = run && more_chk && !out_empty && !out_rd;
  assign wd_hit   = run && more_chk && !pop &&
                    (wd == WD_W'(TIMEOUT_CYCLES - 1));
  assign fin      = run && !more_chk;
  assign issue    = run && !fin && !wd_hit &&
                    (issued < ops) && !in_full && !in_wr;
  assign nib_sum  = {1'b0, c[3:0]} + {1'b0, c[7:4]};
  assign exp_word = {{(DATA_WIDTH-5){1'b0}}, nib_sum};

  user_cl_lfsr8 u_gen (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (accept),
    .adv     (issue),
    .seed    (seed_eff),
    .value   (g)
  );

  user_cl_lfsr8 u_chk (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (accept),
    .adv     (pop),
    .seed    (seed_eff),
    .value   (c)
  );

  // FIFO strobes and operand word, one pulse at most every 2 cycles
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      in_wr   <= 1'b0;
      out_rd  <= 1'b0;
      in_dout <= '0;
    end else begin
      in_wr  <= issue;
      out_rd <= pop;
      if (issue) in_dout <= {{(DATA_WIDTH-8){1'b0}}, g};
    end
  end

  // run control, watchdog and result bookkeeping
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= IDLE;
      ops            <= '0;
      issued         <= '0;
      checked        <= '0;
      wd             <= '0;
      done           <= 1'b0;
      timeout        <= 1'b0;
      pass_count     <= '0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
    end else if (accept) begin
      ops            <= num_ops;
      issued         <= '0;
      checked        <= '0;
      wd             <= '0;
      timeout        <= 1'b0;
      pass_count     <= '0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      done           <= (num_ops == 16'd0);
      state          <= (num_ops == 16'd0) ? DONE : RUN;
    end else if (run) begin
      wd <= pop ? '0 : wd + 1'b1;
      if (issue) issued <= issued + 16'd1;
      if (pop) begin
        checked <= checked + 16'd1;
        if (out_din == exp_word) begin
          if (pass_count != 16'hFFFF)
            pass_count <= pass_count + 16'd1;
        end else begin
          if (err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
          if (err_count == 16'd0) begin
            first_err_idx  <= checked;
            first_err_data <= out_din;
          end
        end
      end
      if (wd_hit) begin
        timeout <= 1'b1;
        done    <= 1'b1;
        state   <= DONE;
      end else if (fin) begin
        done  <= 1'b1;
        state <= DONE;
      end
    end
  end

endmodule

// File: tb/tb_user_cl_adder_stim.sv
// Bench for user_cl_adder_stim: FIFO + 3-cycle adder model,
// table vectors, corner sequences and randomized runs.
module tb_user_cl_adder_stim;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_ops = '0;
  logic [7:0]  seed = '0;
  logic        in_full = 1'b0;
  logic        in_wr;
  logic [31:0] in_dout;
  logic        out_empty = 1'b1;
  logic        out_rd;
  logic [31:0] out_din = '0;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] pass_count;
  logic [15:0] err_count;
  logic [15:0] first_err_idx;
  logic [31:0] first_err_data;

  user_cl_adder_stim dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .num_ops        (num_ops),
    .seed           (seed),
    .in_full        (in_full),
    .in_wr          (in_wr),
    .in_dout        (in_dout),
    .out_empty      (out_empty),
    .out_rd         (out_rd),
    .out_din        (out_din),
    .busy           (busy),
    .done           (done),
    .timeout        (timeout),
    .pass_count     (pass_count),
    .err_count      (err_count),
    .first_err_idx  (first_err_idx),
    .first_err_data (first_err_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          rdy;
    logic [31:0] d;
  } res_t;

  typedef struct {
    logic [7:0]  seed;
    int          n;
    int          bad_idx;
    logic [31:0] bad_val;
    int          e_pass;
    int          e_err;
    int          e_fidx;
    logic [31:0] e_fdata;
  } vec_t;

  int          tests = 0;
  int          failed = 0;
  int          cyc = 0;
  res_t        pipe[$];
  logic [31:0] oq[$];
  logic [31:0] wlog[$];
  int          wcyc[$];
  int          nwr = 0;
  int          nrd = 0;
  int          consec = 0;
  int          wr_full = 0;
  int          underflow = 0;
  bit          full_prev = 1'b0;
  bit          respond = 1'b1;
  bit          hold_full = 1'b0;
  bit          rand_full = 1'b0;
  bit          bad[64];
  logic [31:0] badv[64];

  // input driver for the full flag
  always @(negedge clock) begin
    if (rand_full) in_full = ($urandom_range(0, 2) == 0);
    else in_full = hold_full;
  end

  // FIFO pair plus ideal 3-cycle adder
  always @(posedge clock) begin
    res_t        r;
    logic [31:0] d;
    cyc++;
    if (!reset_n) begin
      pipe.delete();
      oq.delete();
    end else begin
      if (out_rd) begin
        nrd++;
        if (oq.size() > 0) void'(oq.pop_front());
        else underflow++;
      end
      if (in_wr) begin
        if (full_prev) wr_full++;
        if (wcyc.size() > 0 && wcyc[wcyc.size()-1] == cyc - 1)
          consec++;
        wcyc.push_back(cyc);
        wlog.push_back(in_dout);
        if (respond) begin
          d = 32'(in_dout[3:0]) + 32'(in_dout[7:4]);
          if (nwr < 64 && bad[nwr]) d = badv[nwr];
          r.rdy = cyc + 3;
          r.d = d;
          pipe.push_back(r);
        end
        nwr++;
      end
      while (pipe.size() > 0 && pipe[0].rdy <= cyc) begin
        r = pipe.pop_front();
        oq.push_back(r.d);
      end
    end
    full_prev = in_full;
    out_empty <= (oq.size() == 0);
    out_din <= (oq.size() > 0) ? oq[0] : 32'h0;
  end

  function automatic logic [7:0] ref_next(input logic [7:0] b);
    int fb;
    fb = ((b >> 7) ^ (b >> 5) ^ (b >> 4) ^ (b >> 3)) & 1;
    return 8'(((b * 2) & 255) | fb);
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wlog.delete();
    wcyc.delete();
    nwr = 0;
    nrd = 0;
    consec = 0;
    wr_full = 0;
    underflow = 0;
    for (int i = 0; i < 64; i++) begin
      bad[i] = 1'b0;
      badv[i] = '0;
    end
  endtask

  task automatic do_start(input logic [7:0] s, input int n);
    @(negedge clock);
    seed = s;
    num_ops = 16'(n);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = 1;
    while (!done && lat < budget) begin
      @(negedge clock);
      lat++;
    end
    if (!done) chk("wait_done_bound", 0, 1);
    repeat (3) @(negedge clock);
  endtask

  initial begin
    vec_t        vecs[5];
    int          lat;
    int          rel;
    int          first_w;
    int          n;
    int          e_err;
    int          e_fidx;
    int          mism;
    logic [7:0]  s;
    logic [7:0]  l;
    logic [31:0] e_fdata;

    vecs[0] = '{8'h01, 4, -1, 32'h0, 4, 0, 0, 32'h0};
    vecs[1] = '{8'h01, 4, 2, 32'h0, 3, 1, 2, 32'h0};
    vecs[2] = '{8'h00, 3, -1, 32'h0, 3, 0, 0, 32'h0};
    vecs[3] = '{8'hA5, 5, 0, 32'hDEAD, 4, 1, 0, 32'hDEAD};
    vecs[4] = '{8'h3C, 6, 5, 32'h1F0, 5, 1, 5, 32'h1F0};

    clear_log();
    repeat (3) @(negedge clock);
    chk("reset_outputs",
        {in_wr, in_dout, out_rd, busy, done, timeout},
        64'h0);
    chk("reset_counts",
        {pass_count, err_count, first_err_idx}, 64'h0);
    chk("reset_first_data", first_err_data, 64'h0);
    reset_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      clear_log();
      if (vecs[v].bad_idx >= 0) begin
        bad[vecs[v].bad_idx] = 1'b1;
        badv[vecs[v].bad_idx] = vecs[v].bad_val;
      end
      do_start(vecs[v].seed, vecs[v].n);
      wait_done(400, lat);
      chk($sformatf("v%0d_pass", v), pass_count, 64'(vecs[v].e_pass));
      chk($sformatf("v%0d_err", v), err_count, 64'(vecs[v].e_err));
      chk($sformatf("v%0d_fidx", v), first_err_idx,
          64'(vecs[v].e_fidx));
      chk($sformatf("v%0d_fdata", v), first_err_data,
          64'(vecs[v].e_fdata));
      chk($sformatf("v%0d_flags", v), {done, timeout, busy}, 64'b100);
      chk($sformatf("v%0d_pops", v), nrd, 64'(vecs[v].n));
      chk($sformatf("v%0d_underflow", v), underflow, 64'h0);
    end

    clear_log();
    do_start(8'h01, 4);
    wait_done(400, lat);
    chk("seq_len", wlog.size(), 64'd4);
    if (wlog.size() == 4) begin
      chk("seq_w0", wlog[0], 64'h01);
      chk("seq_w1", wlog[1], 64'h02);
      chk("seq_w2", wlog[2], 64'h04);
      chk("seq_w3", wlog[3], 64'h08);
    end

    clear_log();
    do_start(8'h5A, 10);
    lat = 0;
    while (nwr < 3 && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    chk("hold_reach_3_writes", nwr >= 3, 1);
    hold_full = 1'b1;
    repeat (20) @(negedge clock);
    hold_full = 1'b0;
    rel = cyc + 1;
    wait_done(400, lat);
    first_w = -1;
    foreach (wcyc[i])
      if (first_w < 0 && wcyc[i] >= rel) first_w = wcyc[i];
    chk("hold_no_wr_while_full", wr_full, 0);
    chk("hold_resume_2cyc",
        first_w >= rel && first_w <= rel + 2, 1);
    chk("hold_no_consecutive", consec, 0);
    chk("hold_pass", pass_count, 64'd10);
    chk("hold_err", err_count, 64'd0);

    clear_log();
    respond = 1'b0;
    do_start(8'h33, 2);
    wait_done(1200, lat);
    chk("noresp_latency_window", lat >= 1020 && lat <= 1030, 1);
    chk("noresp_flags", {done, timeout, busy}, 64'b110);
    chk("noresp_pass", pass_count, 64'd0);
    chk("noresp_writes", nwr, 64'd2);
    chk("noresp_pops", nrd, 64'd0);
    respond = 1'b1;

    clear_log();
    do_start(8'h21, 0);
    chk("zero_done_next", {done, busy}, 64'b10);
    repeat (4) @(negedge clock);
    chk("zero_no_strobes", nwr + nrd, 64'd0);
    chk("zero_counts", {pass_count, err_count}, 64'd0);

    clear_log();
    do_start(8'h77, 6);
    repeat (3) @(negedge clock);
    seed = 8'h11;
    num_ops = 16'd1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(400, lat);
    chk("busy_start_pass", pass_count, 64'd6);
    chk("busy_start_pops", nrd, 64'd6);
    if (wlog.size() > 0) chk("busy_start_w0", wlog[0], 64'h77);
    else chk("busy_start_w0", 64'hX, 64'h77);

    clear_log();
    do_start(8'h42, 20);
    repeat (8) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk("midreset_outputs",
        {in_wr, in_dout, out_rd, busy, done, timeout}, 64'h0);
    chk("midreset_counts",
        {pass_count, err_count, first_err_idx}, 64'h0);
    reset_n = 1'b1;
    clear_log();
    do_start(8'h00, 3);
    wait_done(400, lat);
    if (wlog.size() > 0) chk("seed0_first_word", wlog[0], 64'h01);
    else chk("seed0_first_word", 64'hX, 64'h01);
    chk("seed0_pass", pass_count, 64'd3);

    for (int it = 0; it < 8; it++) begin
      clear_log();
      s = 8'($urandom);
      n = $urandom_range(1, 30);
      e_err = 0;
      e_fidx = 0;
      e_fdata = '0;
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 4) == 0) begin
          bad[k] = 1'b1;
          badv[k] = $urandom | 32'h8000_0000;
          if (e_err == 0) begin
            e_fidx = k;
            e_fdata = badv[k];
          end
          e_err++;
        end
      end
      rand_full = 1'b1;
      do_start(s, n);
      wait_done(1000, lat);
      rand_full = 1'b0;
      l = (s == 8'h00) ? 8'h01 : s;
      mism = (wlog.size() == n) ? 0 : 1;
      foreach (wlog[i]) begin
        if (wlog[i] !== {24'h0, l}) mism++;
        l = ref_next(l);
      end
      chk($sformatf("r%0d_operands", it), mism, 0);
      chk($sformatf("r%0d_pass", it), pass_count, 64'(n - e_err));
      chk($sformatf("r%0d_err", it), err_count, 64'(e_err));
      chk($sformatf("r%0d_fidx", it), first_err_idx, 64'(e_fidx));
      chk($sformatf("r%0d_fdata", it), first_err_data, 64'(e_fdata));
      chk($sformatf("r%0d_flags", it), {done, timeout}, 64'b10);
      chk($sformatf("r%0d_no_consec", it), consec + wr_full, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1);
  end

endmodule
